key_loader: RTL and testbench

- Upstream stage for the locked benchmark controllers: serially loads a KEY_W-bit unlock key and drives it as a stable parallel bus onto the controller's key inputs (keyinput0..keyinputN-1).
- Until a complete, accepted key is held, it drives a fixed decoy key.
- Registers on posedge clk. The consuming FSM samples on negedge clk, so key_o is always stable for a half-cycle before it is used.

---
 rtl/lock_pkg.sv | 10 +
 rtl/key_shift_reg.sv | 21 ++
 rtl/key_loader.sv | 132 +++++++++++++
 tb/tb_key_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared types and constants for the key loader slice
// Contents: key_ld_state_t (loader FSM states), DECOY_BIT (fill bit of the
// default decoy key), cnt_w() (bit-count width for a given key width).
package lock_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ARMED, ERROR} key_ld_state_t;
    localparam logic DECOY_BIT = 1'b0;
    function automatic int cnt_w(input int key_w);
        return $clog2(key_w + 2);
    endfunction
endpackage

// File: rtl/key_shift_reg.sv
// key_shift_reg: serial-in parallel-out shift register, MSB first
// Ports: clk, rst (async active-high), clr (sync clear, wins over en),
//        en (shift in din), din (serial bit), q (parallel contents).
module key_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    // Truncating cast also covers W=1, where the register is simply loaded.
    always_comb q_d = clr ? '0 : en ? W'({q_q, din}) : q_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/key_loader.sv
// key_loader: serially loads an unlock key and presents it as a stable parallel bus
// Ports: clk, rst (async active-high), load_start_i (begin/restart a load),
//        key_valid_i / key_bit_i (serial key, MSB first), key_ready_o (bit accepted
//        this cycle), key_o (parallel key, DECOY_KEY unless armed), key_armed_o,
//        key_err_o (sticky parity error).
// Build option: KEY_PARITY_CHECK_EN appends an even-parity bit to the serial stream
// and routes a failed check to ERROR; without it key_err_o is tied low.
module key_loader
    import lock_pkg::*;
#(
    parameter int              KEY_W     = 8,
    parameter logic [KEY_W-1:0] DECOY_KEY = {KEY_W{DECOY_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start_i,
    input  logic             key_valid_i,
    input  logic             key_bit_i,
    output logic             key_ready_o,
    output logic [KEY_W-1:0] key_o,
    output logic             key_armed_o,
    output logic             key_err_o
);
    localparam int CW = cnt_w(KEY_W);
`ifdef KEY_PARITY_CHECK_EN
    localparam int N = KEY_W + 1;
`else
    localparam int N = KEY_W;
`endif
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    key_ld_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             armed_q, armed_d;
    logic             err_q, err_d;
    logic [KEY_W-1:0] sreg;
    logic             clr, sh_en, xfer, pass;

    assign xfer = key_valid_i && (state_q == SHIFT);

`ifdef KEY_PARITY_CHECK_EN
    logic par_q, par_d;
    // The parity bit lands in its own flop so the key register holds key bits only.
    always_comb begin
        sh_en = xfer && !load_start_i && (cnt_q != CW'(KEY_W));
        par_d = clr ? 1'b0 : (xfer && !load_start_i && cnt_q == CW'(KEY_W)) ? key_bit_i : par_q;
        pass  = ~(^sreg ^ par_q);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    assign key_err_o = err_q;
`else
    always_comb begin
        sh_en = xfer && !load_start_i;
        pass  = 1'b1;
    end
    assign key_err_o = 1'b0;
`endif

    key_shift_reg #(.W(KEY_W)) u_sreg (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (sh_en),
        .din (key_bit_i),
        .q   (sreg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        armed_d = armed_q;
        err_d   = err_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (load_start_i) begin
                state_d = SHIFT;
                cnt_d   = '0;
                clr     = 1'b1;
            end
            SHIFT: if (load_start_i) begin
                cnt_d = '0;
                clr   = 1'b1;
            end else if (key_valid_i) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? CHECK : SHIFT;
            end
            CHECK: begin
                state_d = pass ? ARMED : ERROR;
                key_d   = pass ? sreg : DECOY_KEY;
                armed_d = pass;
                err_d   = !pass;
            end
            ARMED: if (load_start_i) begin
                state_d = SHIFT;
                cnt_d   = '0;
                clr     = 1'b1;
                key_d   = DECOY_KEY;
                armed_d = 1'b0;
            end
            ERROR: if (load_start_i) begin
                state_d = SHIFT;
                cnt_d   = '0;
                clr     = 1'b1;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= DECOY_KEY;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            armed_q <= armed_d;
            err_q   <= err_d;
        end

    assign key_ready_o = (state_q == SHIFT);
    assign key_o       = key_q;
    assign key_armed_o = armed_q;
endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: directed self-checking bench for key_loader (KEY_W=8 and KEY_W=1)
module tb_key_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start_i = 1'b0, key_valid_i = 1'b0, key_bit_i = 1'b0;
    logic       key_ready_o, key_armed_o, key_err_o;
    logic [7:0] key_o;
    logic       s_start = 1'b0, s_valid = 1'b0, s_bit = 1'b0;
    logic       s_ready, s_armed, s_err;
    logic [0:0] s_key;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    key_loader #(.KEY_W(8)) dut (
        .clk(clk), .rst(rst), .load_start_i(load_start_i), .key_valid_i(key_valid_i),
        .key_bit_i(key_bit_i), .key_ready_o(key_ready_o), .key_o(key_o),
        .key_armed_o(key_armed_o), .key_err_o(key_err_o)
    );

    key_loader #(.KEY_W(1)) dut1 (
        .clk(clk), .rst(rst), .load_start_i(s_start), .key_valid_i(s_valid),
        .key_bit_i(s_bit), .key_ready_o(s_ready), .key_o(s_key),
        .key_armed_o(s_armed), .key_err_o(s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        repeat ($urandom_range(0, 2)) tick();
        key_valid_i = 1'b1;
        key_bit_i   = b;
        tick();
        key_valid_i = 1'b0;
        key_bit_i   = 1'b0;
    endtask

    task automatic load_key(input logic [7:0] k, input logic p);
        logic bad;
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        check("ready_after_start", 32'(key_ready_o), 1);
        check("decoy_after_start", 32'(key_o), 0);
        for (int i = 7; i >= 0; i--) send_bit(k[i]);
`ifdef KEY_PARITY_CHECK_EN
        send_bit(p);
        bad = (^k) ^ p;
`else
        bad = 1'b0;
`endif
        check("ready_after_last", 32'(key_ready_o), 0);
        check("decoy_in_check", 32'(key_o), 0);
        tick();
        check("key_loaded", 32'(key_o), bad ? 0 : 32'(k));
        check("armed_loaded", 32'(key_armed_o), bad ? 0 : 1);
        check("err_loaded", 32'(key_err_o), bad ? 1 : 0);
    endtask

    initial begin
        logic stable;
        repeat (2) tick();
        check("rst_key", 32'(key_o), 0);
        check("rst_armed", 32'(key_armed_o), 0);
        check("rst_ready", 32'(key_ready_o), 0);
        check("rst_err", 32'(key_err_o), 0);
        rst = 1'b0;
        tick();
        check("idle_ready", 32'(key_ready_o), 0);

        load_key(8'hA5, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            key_valid_i = 1'($urandom_range(0, 1));
            key_bit_i   = 1'($urandom_range(0, 1));
            tick();
            stable &= (key_o == 8'hA5) && key_armed_o && !key_ready_o;
        end
        key_valid_i = 1'b0;
        check("hold_100", 32'(stable), 1);

        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        check("reload_key_decoy", 32'(key_o), 0);
        check("reload_armed", 32'(key_armed_o), 0);
        check("reload_ready", 32'(key_ready_o), 1);
        for (int i = 7; i >= 0; i--) send_bit(8'h3C >> i);
`ifdef KEY_PARITY_CHECK_EN
        send_bit(^8'h3C);
`endif
        tick();
        check("key_3c", 32'(key_o), 32'h3C);

        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        repeat (4) send_bit(1'b1);
        load_start_i = 1'b1;
        key_valid_i  = 1'b1;
        key_bit_i    = 1'b1;
        tick();
        load_start_i = 1'b0;
        key_valid_i  = 1'b0;
        check("restart_ready", 32'(key_ready_o), 1);
        for (int i = 7; i >= 0; i--) send_bit(8'h81 >> i);
`ifdef KEY_PARITY_CHECK_EN
        send_bit(^8'h81);
`endif
        check("restart_check_ready", 32'(key_ready_o), 0);
        tick();
        check("key_81", 32'(key_o), 32'h81);
        check("armed_81", 32'(key_armed_o), 1);

        #2 rst = 1'b1;
        #1;
        check("async_rst_key", 32'(key_o), 0);
        check("async_rst_armed", 32'(key_armed_o), 0);
        rst = 1'b0;
        tick();

        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        repeat (5) send_bit(1'b1);
        check("mid_ready", 32'(key_ready_o), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(key_ready_o), 0);
        check("mid_rst_key", 32'(key_o), 0);
        rst = 1'b0;
        key_valid_i = 1'b1;
        key_bit_i   = 1'b1;
        repeat (3) tick();
        key_valid_i = 1'b0;
        check("post_rst_ready", 32'(key_ready_o), 0);
        check("post_rst_armed", 32'(key_armed_o), 0);

`ifdef KEY_PARITY_CHECK_EN
        load_key(8'hA5, 1'b0);
        load_key(8'hA5, 1'b1);
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        check("err_cleared", 32'(key_err_o), 0);
        check("err_clear_ready", 32'(key_ready_o), 1);
`endif

        check("w1_decoy_idle", 32'(s_key), 0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("w1_ready", 32'(s_ready), 1);
        tick();
        check("w1_decoy_wait", 32'(s_key), 0);
        s_valid = 1'b1;
        s_bit   = 1'b1;
        tick();
`ifdef KEY_PARITY_CHECK_EN
        tick();
`endif
        s_valid = 1'b0;
        s_bit   = 1'b0;
        check("w1_ready_done", 32'(s_ready), 0);
        check("w1_decoy_check", 32'(s_key), 0);
        tick();
        check("w1_key", 32'(s_key), 1);
        check("w1_armed", 32'(s_armed), 1);
        check("w1_err", 32'(s_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
